// File: rtl/serial_subtractor_if.sv
// Valid/ready operand and result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned W = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, one bit per clock: diff = a + ~b + 1.
// Operands are accepted in IDLE, shifted through RUN for W edges, and held in DONE.
module serial_subtractor #(
  parameter int unsigned W = 8
) (
  input logic                 clk,
  input logic                 aresetn,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CntW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      diff_q, diff_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              borrow_q, borrow_d;
  logic              ovf_q, ovf_d;

  logic              nb_bit;
  logic              sum_bit;
  logic              carry_out;
  logic              last_bit;
  logic              accept;

  assign nb_bit    = ~b_q[0];
  assign sum_bit   = a_q[0] ^ nb_bit ^ carry_q;
  assign carry_out = (a_q[0] & nb_bit) | (a_q[0] & carry_q) | (nb_bit & carry_q);
  assign last_bit  = (cnt_q == CntW'(W - 1));
  assign accept    = bus.in_valid && in_ready_q;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    borrow_d    = borrow_q;
    ovf_d       = ovf_q;
    case (state_q)
      StIdle: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (accept) begin
          a_d        = bus.a;
          b_d        = bus.b;
          carry_d    = 1'b1;
          cnt_d      = '0;
          in_ready_d = 1'b0;
        end
      end
      StRun: begin
        in_ready_d = 1'b0;
        a_d        = a_q >> 1;
        b_d        = b_q >> 1;
        diff_d     = {sum_bit, diff_q[W-1:1]};
        carry_d    = carry_out;
        if (last_bit) begin
          // carry_q here is the carry into the MSB
          out_valid_d = 1'b1;
          borrow_d    = ~carry_out;
          ovf_d       = carry_q ^ carry_out;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at W=8 and W=3 with a result scoreboard.
module tb_serial_subtractor;

  logic clk;
  logic aresetn;

  serial_subtractor_if #(.W(8)) i8 ();
  serial_subtractor_if #(.W(3)) i3 ();

  serial_subtractor #(.W(8)) u_dut8 (.clk(clk), .aresetn(aresetn), .bus(i8));
  serial_subtractor #(.W(3)) u_dut3 (.clk(clk), .aresetn(aresetn), .bus(i3));

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];

  int tests_run = 0;
  int tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready8();
    int n = 0;
    @(negedge clk);
    while (!i8.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready8_wait", 32'(i8.in_ready), 32'd1);
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input int stall);
    exp_t       e;
    int         lat;
    logic [7:0] hd;
    logic       hb, ho;
    e.diff   = av - bv;
    e.borrow = (av < bv);
    e.ovf    = (av[7] != bv[7]) && (e.diff[7] != av[7]);
    wait_ready8();
    i8.in_valid = 1'b1;
    i8.a        = av;
    i8.b        = bv;
    q8.push_back(e);
    @(posedge clk);
    #1;
    i8.in_valid = 1'b0;
    i8.a        = 8'($urandom);
    i8.b        = 8'($urandom);
    check("in_ready8_busy", 32'(i8.in_ready), 32'd0);
    lat = 0;
    while (!i8.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency8", 32'(lat), 32'd8);
    hd = i8.diff;
    hb = i8.borrow;
    ho = i8.ovf;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      i8.in_valid = 1'b1;  // must be ignored outside IDLE
      check("stall_valid8", 32'(i8.out_valid), 32'd1);
      check("stall_ready8", 32'(i8.in_ready), 32'd0);
      check("stall_diff8", 32'(i8.diff), 32'(hd));
      check("stall_flags8", {30'd0, i8.borrow, i8.ovf}, {30'd0, hb, ho});
    end
    @(negedge clk);
    i8.in_valid  = 1'b0;
    i8.out_ready = 1'b1;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      check("diff8", 32'(i8.diff), 32'(e.diff));
      check("borrow8", 32'(i8.borrow), 32'(e.borrow));
      check("ovf8", 32'(i8.ovf), 32'(e.ovf));
    end else begin
      check("scoreboard8_empty", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    i8.out_ready = 1'b0;
    check("post_valid8", 32'(i8.out_valid), 32'd0);
    check("post_ready8", 32'(i8.in_ready), 32'd1);
  endtask

  initial begin
    int   stale;
    exp_t e;
    aresetn      = 1'b0;
    i8.in_valid  = 1'b0;
    i8.a         = '0;
    i8.b         = '0;
    i8.out_ready = 1'b0;
    i3.in_valid  = 1'b0;
    i3.a         = '0;
    i3.b         = '0;
    i3.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(i8.in_ready), 32'd0);
    check("rst_out_valid", 32'(i8.out_valid), 32'd0);
    check("rst_diff", 32'(i8.diff), 32'd0);
    check("rst_flags", {30'd0, i8.borrow, i8.ovf}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    check("first_in_ready", 32'(i8.in_ready), 32'd1);

    op8(8'h05, 8'h03, 0);
    op8(8'h03, 8'h05, 0);
    op8(8'h80, 8'h01, 0);
    op8(8'h7F, 8'hFF, 5);
    op8(8'hFF, 8'hFF, 2);
    op8(8'h00, 8'h80, 1);

    // Abort mid-RUN: reset sampled while cnt==3
    wait_ready8();
    i8.in_valid = 1'b1;
    i8.a        = 8'h5A;
    i8.b        = 8'h33;
    e.diff      = 8'h27;
    e.borrow    = 1'b0;
    e.ovf       = 1'b0;
    q8.push_back(e);
    @(posedge clk);
    #1;
    i8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b0;
    q8.delete();
    @(posedge clk);
    #1;
    check("abort_out_valid", 32'(i8.out_valid), 32'd0);
    check("abort_diff", 32'(i8.diff), 32'd0);
    check("abort_in_ready", 32'(i8.in_ready), 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (i8.out_valid) stale++;
    end
    check("abort_no_stale", 32'(stale), 32'd0);
    op8(8'h10, 8'h20, 0);

    // W=3 exhaustive with random backpressure
    for (int av = 0; av < 8; av++) begin
      for (int bv = 0; bv < 8; bv++) begin
        int sa, sb, sd, n, fails_before;
        bit done;
        fails_before = tests_failed;
        sa = (av >= 4) ? av - 8 : av;
        sb = (bv >= 4) ? bv - 8 : bv;
        sd = sa - sb;
        e.diff   = 8'((av - bv) & 7);
        e.borrow = (av < bv);
        e.ovf    = (sd < -4) || (sd > 3);
        n = 0;
        @(negedge clk);
        while (!i3.in_ready && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("in_ready3_wait", 32'(i3.in_ready), 32'd1);
        i3.in_valid = 1'b1;
        i3.a        = 3'(av);
        i3.b        = 3'(bv);
        q3.push_back(e);
        @(posedge clk);
        #1;
        i3.in_valid = 1'b0;
        i3.a        = 3'($urandom);
        i3.b        = 3'($urandom);
        done = 1'b0;
        n    = 0;
        while (!done && n < 60) begin
          @(negedge clk);
          i3.out_ready = 1'($urandom_range(0, 1));
          n++;
          if (i3.out_valid && i3.out_ready) begin
            e = q3.pop_front();
            check("diff3", 32'(i3.diff), 32'(e.diff));
            check("borrow3", 32'(i3.borrow), 32'(e.borrow));
            check("ovf3", 32'(i3.ovf), 32'(e.ovf));
            done = 1'b1;
          end
        end
        @(posedge clk);
        #1;
        i3.out_ready = 1'b0;
        if (!done) check("timeout3", 32'd0, 32'd1);
        if (tests_failed == fails_before)
          $display("[TB] W3 %0d-%0d PASS", av, bv);
        else
          $display("[TB] W3 %0d-%0d FAIL", av, bv);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
